// File: rtl/pc_fetch_stage.sv
// Fetch stage: the PC register, the PC+4 incrementer and the IF/ID pipeline register.
// Redirect, stall and flush controls come from the EX stage and the hazard unit.
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    input  logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic [31:0] pc_plus4_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic        misalign_e
);

    logic [31:0] pc_r;
    logic [31:0] pc_next_s;
    logic [31:0] pc_plus4_s;
    logic        misalign_r;
    logic        misalign_next_s;

    logic [31:0] instr_d_r;
    logic [31:0] pc_d_r;
    logic [31:0] pc_plus4_d_r;
    logic        valid_d_r;

    logic [31:0] instr_d_next_s;
    logic [31:0] pc_d_next_s;
    logic [31:0] pc_plus4_d_next_s;
    logic        valid_d_next_s;

    // Sequential PC increment; wraps silently past 0xFFFF_FFFC.
    always_comb begin
        pc_plus4_s = pc_r + 32'd4;
    end

    // PC next-state: a redirect beats a stall so a taken branch is never lost.
    always_comb begin
        pc_next_s       = pc_plus4_s;
        misalign_next_s = 1'b0;
        if (pc_src_e) begin
            pc_next_s       = {pc_target_e[31:2], 2'b00};
            misalign_next_s = (pc_target_e[1:0] != 2'b00);
        end else if (stall_f) begin
            pc_next_s       = pc_r;
            misalign_next_s = 1'b0;
        end else begin
            pc_next_s       = pc_plus4_s;
            misalign_next_s = 1'b0;
        end
    end

    // IF/ID next-state: flush wins over stall; otherwise capture the fetched word.
    always_comb begin
        instr_d_next_s    = instr_d_r;
        pc_d_next_s       = pc_d_r;
        pc_plus4_d_next_s = pc_plus4_d_r;
        valid_d_next_s    = valid_d_r;
        if (flush_d) begin
            instr_d_next_s    = NOP_INSTR;
            pc_d_next_s       = 32'h0000_0000;
            pc_plus4_d_next_s = 32'h0000_0000;
            valid_d_next_s    = 1'b0;
        end else if (stall_d) begin
            instr_d_next_s    = instr_d_r;
            pc_d_next_s       = pc_d_r;
            pc_plus4_d_next_s = pc_plus4_d_r;
            valid_d_next_s    = valid_d_r;
        end else begin
            instr_d_next_s    = instr_f;
            pc_d_next_s       = pc_r;
            pc_plus4_d_next_s = pc_plus4_s;
            valid_d_next_s    = 1'b1;
        end
    end

    // PC and misalignment flag registers; reset discards any pending redirect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r       <= RESET_PC;
            misalign_r <= 1'b0;
        end else begin
            pc_r       <= pc_next_s;
            misalign_r <= misalign_next_s;
        end
    end

    // IF/ID pipeline register; reset loads a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_d_r    <= NOP_INSTR;
            pc_d_r       <= 32'h0000_0000;
            pc_plus4_d_r <= 32'h0000_0000;
            valid_d_r    <= 1'b0;
        end else begin
            instr_d_r    <= instr_d_next_s;
            pc_d_r       <= pc_d_next_s;
            pc_plus4_d_r <= pc_plus4_d_next_s;
            valid_d_r    <= valid_d_next_s;
        end
    end

    assign pc_f       = pc_r;
    assign pc_plus4_f = pc_plus4_s;
    assign instr_d    = instr_d_r;
    assign pc_d       = pc_d_r;
    assign pc_plus4_d = pc_plus4_d_r;
    assign valid_d    = valid_d_r;
    assign misalign_e = misalign_r;

endmodule
